cla_addsub_pipe: RTL and testbench



---
 rtl/cla_addsub_pipe.sv | 191 +++++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//
// Pipelined carry-lookahead adder/subtractor. The operand width is cut into
// GROUP-bit slices; slice k is added in pipeline stage k from the carry that
// stage k-1 registered, so one slice's worth of lookahead logic sits between
// any two register levels. Higher operand slices travel down the pipe
// unmodified until their stage comes up. Finished low slices travel with
// them, so S leaves the last stage as one aligned word.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode presented
//   in_ready   block accepts operands this cycle
//   A, B       operands (WIDTH bits)
//   sub        0 = A + B + cin, 1 = A - B - cin
//   cin        carry-in (add) / borrow-in (subtract)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   S          sum / difference (WIDTH bits)
//   cout       raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       S == 0
//
// WIDTH must be a multiple of GROUP. GROUP must be a multiple of 4.
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / GROUP;
    localparam int NGRP   = GROUP / 4;

    // One GROUP-bit slice. It uses 4-bit P/G groups, and lookahead across
    // the groups (sum-of-products, no group-to-group ripple).
    // Result layout: {carry into slice MSB, carry out of slice, sum}.
    function automatic logic [GROUP+1:0] slice_add(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             c
    );
        logic [GROUP-1:0] p, g, cb;
        logic [NGRP-1:0]  gp, gg;
        logic [NGRP:0]    gc;
        logic             t, pr;
        p = a ^ b;
        g = a & b;
        for (int j = 0; j < NGRP; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = c;
        for (int j = 0; j < NGRP; j++) begin
            // Carry into group j+1: c propagated through all groups 0..j,
            // OR any group i generating and groups i+1..j propagating.
            t = c;
            for (int i = 0; i <= j; i++) t = t & gp[i];
            for (int i = 0; i <= j; i++) begin
                pr = gg[i];
                for (int m = i + 1; m <= j; m++) pr = pr & gp[m];
                t = t | pr;
            end
            gc[j+1] = t;
        end
        for (int j = 0; j < NGRP; j++) begin
            cb[4*j]   = gc[j];
            cb[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            cb[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                      | (p[4*j+1] & p[4*j] & gc[j]);
            cb[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                      | (p[4*j+2] & p[4*j+1] & g[4*j])
                      | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {cb[GROUP-1], gc[NGRP], p ^ cb};
    endfunction

    logic              advance;
    logic [STAGES-1:0] v_reg;
    logic [STAGES-1:0] vin;

    // Register level k holds stage k's result. x carries finished sum bits
    // below the slice boundary and untouched A bits above it. y carries the
    // effective B operand. The last level is the output register set below,
    // so element STAGES-1 of these arrays is never used.
    logic [WIDTH-1:0] x_reg [STAGES];
    logic [WIDTH-1:0] y_reg [STAGES];
    logic             c_reg [STAGES];

    logic [WIDTH-1:0] xin  [STAGES];
    logic [WIDTH-1:0] yin  [STAGES];
    logic [WIDTH-1:0] xout [STAGES];
    logic             cin_s [STAGES];
    logic [GROUP+1:0] res  [STAGES];

    logic [WIDTH-1:0] s_reg;
    logic             cout_reg, ovf_reg, zero_reg;

    // A single global enable. The pipe moves whenever the output slot is
    // empty or is being drained this cycle.
    assign out_valid = v_reg[STAGES-1];
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam logic [WIDTH-1:0] SLICE_MASK =
                WIDTH'({GROUP{1'b1}}) << (gi * GROUP);

            if (gi == 0) begin : g_src
                // Subtract is A + ~B + 1. The borrow-in flips that injected 1.
                assign xin[gi]   = A;
                assign yin[gi]   = B ^ {WIDTH{sub}};
                assign cin_s[gi] = cin ^ sub;
                assign vin[gi]   = in_valid;
            end else begin : g_src
                assign xin[gi]   = x_reg[gi-1];
                assign yin[gi]   = y_reg[gi-1];
                assign cin_s[gi] = c_reg[gi-1];
                assign vin[gi]   = v_reg[gi-1];
            end

            assign res[gi]  = slice_add(xin[gi][gi*GROUP +: GROUP],
                                        yin[gi][gi*GROUP +: GROUP],
                                        cin_s[gi]);
            assign xout[gi] = (xin[gi] & ~SLICE_MASK)
                            | (WIDTH'(res[gi][GROUP-1:0]) << (gi * GROUP));

            if (gi < STAGES - 1) begin : g_reg
                // Data only loads with a valid beat, so bubbles cost no toggles.
                always_ff @(posedge clk) begin
                    if (advance && vin[gi]) begin
                        x_reg[gi] <= xout[gi];
                        y_reg[gi] <= yin[gi];
                        c_reg[gi] <= res[gi][GROUP];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg <= '0;
        end else if (advance) begin
            v_reg <= vin;
        end
    end

    // The outputs only change when a valid beat arrives. When a bubble
    // arrives they keep the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else if (advance && vin[STAGES-1]) begin
            s_reg    <= xout[STAGES-1];
            cout_reg <= res[STAGES-1][GROUP];
            ovf_reg  <= res[STAGES-1][GROUP+1] ^ res[STAGES-1][GROUP];
            zero_reg <= ~|xout[STAGES-1];
        end
    end

    assign S    = s_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign zero = zero_reg;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
module tb_cla_addsub_pipe;

    localparam int W   = 32;
    localparam int G   = 16;
    localparam int NST = W / G;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_drv = '0;
    logic [W-1:0] b_drv = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s_obs;
    logic         cout, ovf, zero;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sb;
        logic         ci;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    int   delivered = 0;

    cla_addsub_pipe #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_drv),
        .B         (b_drv),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s_obs),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the mode rules. Signed overflow
    // is judged by whether the true signed result fits in W bits.
    function automatic exp_t ref_model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                       input logic sbi, input logic cii);
        exp_t   e;
        longint m, half, ua, ub, c0, sum, sa, sbv, ssum;
        m    = longint'(1) << W;
        half = longint'(1) << (W - 1);
        ua   = longint'(ai);
        ub   = sbi ? (m - 1 - longint'(bi)) : longint'(bi);
        c0   = (cii != sbi) ? 1 : 0;
        sum  = ua + ub + c0;
        e.s  = sum[W-1:0];
        e.c  = (sum >= m);
        sa   = (ua >= half) ? ua - m : ua;
        sbv  = (ub >= half) ? ub - m : ub;
        ssum = sa + sbv + c0;
        e.o  = (ssum >= half) || (ssum < -half);
        e.z  = (e.s == '0);
        e.a  = ai;
        e.b  = bi;
        e.sb = sbi;
        e.ci = cii;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: the negedge sits between the driver's updates and the next
    // active edge, so handshakes seen here are the ones that edge will take.
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_s;
    logic [2:0]   held_f;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("stall_s", s_obs, held_s);
                    check_eq("stall_flags", {cout, ovf, zero}, held_f);
                    check_eq("stall_valid", out_valid, 1'b1);
                end
                if (out_valid && !out_ready)
                    check_eq("stall_in_ready", in_ready, 1'b0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_out", out_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("res_s", s_obs, e.s);
                        check_eq("res_flags", {cout, ovf, zero}, {e.c, e.o, e.z});
                        delivered++;
                        $display("out #%0d a=%h b=%h sub=%0d cin=%0d -> s=%h c=%0d v=%0d z=%0d",
                                 delivered, e.a, e.b, e.sb, e.ci, s_obs, cout, ovf, zero);
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back(ref_model(a_drv, b_drv, sub, cin));
                stall_prev = out_valid && !out_ready;
                held_s     = s_obs;
                held_f     = {cout, ovf, zero};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand_op();
        a_drv = rnd_operand();
        b_drv = rnd_operand();
        sub   = 1'($urandom_range(0, 1));
        cin   = 1'($urandom_range(0, 1));
    endtask

    // One op into an idle pipe. Checks latency and constant expected outputs.
    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic sbi, input logic cii, input logic [W-1:0] want_s,
                          input logic want_c, input logic want_o, input logic want_z);
        int n;
        out_ready = 1'b1;
        a_drv = ai; b_drv = bi; sub = sbi; cin = cii;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, n, NST);
        check_eq({tag, "_s"}, s_obs, want_s);
        check_eq({tag, "_cout"}, cout, want_c);
        check_eq({tag, "_ovf"}, ovf, want_o);
        check_eq({tag, "_zero"}, zero, want_z);
        tick();
    endtask

    initial begin
        int  issued, base, cyc, not_rdy, idx;
        bit  rp  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit  pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic want_v;

        // Reset state
        #1 rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_s", s_obs, '0);
        check_eq("rst_flags", {cout, ovf, zero}, 3'b000);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        tick();

        // Directed arithmetic
        run_op("add_xslice", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        run_op("sub_zero",   32'h12345678, 32'h12345678, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_op("sub_borrow", 32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_bin",    32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0);
        run_op("add_cin",    32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);

        // Backpressure: out_ready cycles 1,0,0,1
        issued = 0;
        base   = delivered;
        cyc    = 0;
        while ((delivered - base < 8) && cyc < 200) begin
            out_ready = rp[cyc % 4];
            if (issued < 8) begin
                in_valid = 1'b1;
                set_rand_op();
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) issued++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_issued", issued, 8);
        check_eq("bp_delivered", delivered - base, 8);
        check_eq("bp_queue", exp_q.size(), 0);
        tick();
        tick();

        // Bubbles: valid pattern must reappear NST cycles later, uncompressed
        for (int i = 0; i < 4 + NST + 1; i++) begin
            in_valid = (i < 4) ? pat[i] : 1'b0;
            set_rand_op();
            tick();
            idx    = i + 1 - NST;
            want_v = (idx >= 0 && idx < 4) ? pat[idx] : 1'b0;
            check_eq("bubble_valid", out_valid, want_v);
        end
        in_valid = 1'b0;
        tick();

        // Full rate: 100 back-to-back ops, one result per cycle
        base    = delivered;
        not_rdy = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            set_rand_op();
            #1;
            if (!in_ready) not_rdy++;
            tick();
        end
        in_valid = 1'b0;
        repeat (NST) tick();
        check_eq("rate_not_ready", not_rdy, 0);
        check_eq("rate_delivered", delivered - base, 100);
        tick();
        check_eq("rate_no_dup", delivered - base, 100);

        // Reset with ops in flight
        out_ready = 1'b1;
        a_drv = 32'hFFFFFFFF; b_drv = 32'h00000001; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        tick();
        a_drv = 32'h00000005; b_drv = 32'h00000007; sub = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("midrst_inflight", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("midrst_valid", out_valid, 1'b0);
        check_eq("midrst_s", s_obs, '0);
        check_eq("midrst_flags", {cout, ovf, zero}, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("midrst_in_ready", in_ready, 1'b1);
        repeat (4) tick();
        check_eq("midrst_no_stale", out_valid, 1'b0);
        run_op("post_rst", 32'h00000100, 32'h00000023, 1'b0, 1'b0, 32'h00000123, 1'b0, 1'b0, 1'b0);

        tick();
        check_eq("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "simulation timeout");
    end

endmodule
